// File: rtl/a2f_pkg.sv
// ============================================================================
// Module      : a2f_pkg
// Description : Shared types and constants for the FPGA-to-FTDI return merger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package a2f_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HDR      = 2'd1,
        ST_IQ_BURST = 2'd2,
        ST_CPU_MSG  = 2'd3
    } a2f_state_e;

    typedef enum logic {
        SRC_IQ  = 1'b0,
        SRC_CPU = 1'b1
    } a2f_src_e;

    localparam logic [6:0] c_hdr_sync      = 7'h55;
    localparam int          c_hdr_src_bit   = 23;
    localparam int          c_hdr_sync_lsb  = 16;
    localparam int          c_hdr_frame_lsb = 0;

    typedef struct packed {
        logic     hit;
        a2f_src_e src;
    } a2f_arb_t;

    // ECPU wins unless it also held the previous grant and IQ is waiting.
    function automatic a2f_arb_t a2f_arbitrate(
        input logic     cpu_valid,
        input logic     fifo_empty,
        input a2f_src_e last_src
    );
        a2f_arb_t r;
        r.hit = 1'b1;
        r.src = last_src;
        if (cpu_valid && !(last_src == SRC_CPU && !fifo_empty)) begin
            r.src = SRC_CPU;
        end else if (!fifo_empty) begin
            r.src = SRC_IQ;
        end else begin
            r.hit = 1'b0;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/a2f_out_reg.sv
// ============================================================================
// Module      : a2f_out_reg
// Description : One-entry output holding register (data, we, src) toward FTDI.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module a2f_out_reg
    import a2f_pkg::*;
#(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  i_rdy,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  a2f_src_e              i_src,
    output logic                  o_load,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_we,
    output logic                  o_src
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_we;
    a2f_src_e              r_src;

    assign o_load = !r_we | i_rdy;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data <= '0;
            r_we   <= 1'b0;
            r_src  <= SRC_IQ;
        end else if (o_load) begin
            r_we  <= i_valid;
            r_src <= i_src;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_data = r_data;
    assign o_we   = r_we;
    assign o_src  = r_src;

endmodule

`default_nettype wire

// File: rtl/a2f_mux.sv
// ============================================================================
// Module      : a2f_mux
// Description : Merges IQ FIFO bursts and atomic ECPU messages into one
//               registered FTDI word stream. A2F_HDR_EN adds a header word
//               before every grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module a2f_mux
    import a2f_pkg::*;
#(
    parameter int IQ_DATA_WIDTH = 24,
    parameter int BURST_LEN     = 64
`ifdef A2F_HDR_EN
    ,
    parameter logic [15:0] FRAME_INIT = 16'h0000
`endif
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [IQ_DATA_WIDTH-1:0] fifo_data_i,
    input  logic                     fifo_empty_i,
    output logic                     fifo_re_o,
    input  logic [IQ_DATA_WIDTH-1:0] cpu_data_i,
    input  logic                     cpu_valid_i,
    input  logic                     cpu_last_i,
    output logic                     cpu_re_o,
    output logic [IQ_DATA_WIDTH-1:0] a2f_data_o,
    output logic                     a2f_we_o,
    input  logic                     a2f_rdy_i,
    output logic                     a2f_src_o
);

    localparam logic [15:0] c_burst_last = 16'(BURST_LEN - 1);

    a2f_state_e               r_state;
    a2f_state_e               w_state_nxt;
    a2f_state_e               w_grant_state;
    a2f_src_e                 r_last_src;
    a2f_src_e                 w_cur_src;
    a2f_arb_t                 w_arb;
    logic [15:0]              r_burst_cnt;
    logic                     w_load;
    logic                     w_ld_valid;
    logic [IQ_DATA_WIDTH-1:0] w_ld_data;
    logic                     w_grant_end;
    logic                     w_grant_start;

    assign w_arb = a2f_arbitrate(cpu_valid_i, fifo_empty_i, r_last_src);

`ifdef A2F_HDR_EN
    logic [15:0]              r_frame;
    logic                     w_hdr_load;
    logic [IQ_DATA_WIDTH-1:0] w_hdr_word;

    assign w_grant_state = ST_HDR;

    always_comb begin
        w_hdr_word                               = '0;
        w_hdr_word[c_hdr_src_bit]                = r_last_src;
        w_hdr_word[c_hdr_sync_lsb +: 7]          = c_hdr_sync;
        w_hdr_word[c_hdr_frame_lsb +: 16]        = r_frame;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_frame <= FRAME_INIT;
        end else if (w_hdr_load) begin
            r_frame <= r_frame + 16'd1;
        end
    end
`else
    assign w_grant_state = (w_arb.src == SRC_CPU) ? ST_CPU_MSG : ST_IQ_BURST;
`endif

    // Pops are only issued in a load cycle so the popped word always lands.
    always_comb begin
        w_state_nxt = r_state;
        fifo_re_o   = 1'b0;
        cpu_re_o    = 1'b0;
        w_ld_valid  = 1'b0;
        w_ld_data   = fifo_data_i;
        w_cur_src   = r_last_src;
        w_grant_end = 1'b0;
`ifdef A2F_HDR_EN
        w_hdr_load  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_grant_end = 1'b1;
            end
            ST_IQ_BURST: begin
                w_cur_src = SRC_IQ;
                if (w_load) begin
                    if (!fifo_empty_i) begin
                        fifo_re_o   = 1'b1;
                        w_ld_valid  = 1'b1;
                        w_grant_end = (r_burst_cnt == c_burst_last);
                    end else begin
                        w_grant_end = 1'b1;
                    end
                end
            end
            ST_CPU_MSG: begin
                w_cur_src = SRC_CPU;
                if (w_load && cpu_valid_i) begin
                    cpu_re_o    = 1'b1;
                    w_ld_valid  = 1'b1;
                    w_ld_data   = cpu_data_i;
                    w_grant_end = cpu_last_i;
                end
            end
`ifdef A2F_HDR_EN
            ST_HDR: begin
                if (w_load) begin
                    w_ld_valid  = 1'b1;
                    w_ld_data   = w_hdr_word;
                    w_hdr_load  = 1'b1;
                    w_state_nxt = (r_last_src == SRC_CPU) ? ST_CPU_MSG : ST_IQ_BURST;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_grant_start = w_grant_end & w_arb.hit;
        if (w_grant_end) begin
            w_state_nxt = w_arb.hit ? w_grant_state : ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_last_src  <= SRC_IQ;
            r_burst_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_start) begin
                r_last_src <= w_arb.src;
            end
            if (w_grant_start || r_state != ST_IQ_BURST) begin
                r_burst_cnt <= 16'd0;
            end else if (fifo_re_o) begin
                r_burst_cnt <= r_burst_cnt + 16'd1;
            end
        end
    end

    a2f_out_reg #(
        .DATA_WIDTH (IQ_DATA_WIDTH)
    ) u_out_reg (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_rdy   (a2f_rdy_i),
        .i_valid (w_ld_valid),
        .i_data  (w_ld_data),
        .i_src   (w_cur_src),
        .o_load  (w_load),
        .o_data  (a2f_data_o),
        .o_we    (a2f_we_o),
        .o_src   (a2f_src_o)
    );

endmodule

`default_nettype wire

// File: doc/a2f_mux.md
# a2f_mux

Return-path merger from FPGA to FTDI. It arbitrates between the IQ sample FIFO (read side, show-ahead) and the ECPU message source, and drives a single registered word stream into the FTDI write port. It is the counterpart of the FTDI-to-FIFO/ECPU splitter. IQ data moves in bounded bursts; ECPU messages move atomically.

## Interface
Parameters:
- IQ_DATA_WIDTH, 24, word width on every data port
- BURST_LEN, 64, maximum IQ words per grant (2..65535)

Ports:
- clk_i  in  1  single clock for all logic
- rst_n_i  in  1  asynchronous assert, active-low reset
- fifo_data_i  in  IQ_DATA_WIDTH  IQ FIFO head word, valid while !fifo_empty_i
- fifo_empty_i  in  1  IQ FIFO empty
- fifo_re_o  out  1  pop IQ FIFO head (combinational)
- cpu_data_i  in  IQ_DATA_WIDTH  ECPU message word
- cpu_valid_i  in  1  cpu_data_i valid
- cpu_last_i  in  1  current word ends the message
- cpu_re_o  out  1  pop ECPU word (combinational)
- a2f_data_o  out  IQ_DATA_WIDTH  word to FTDI (registered)
- a2f_we_o  out  1  a2f_data_o valid (registered)
- a2f_rdy_i  in  1  FTDI accepts; transfer = a2f_we_o & a2f_rdy_i
- a2f_src_o  out  1  current grant: 0 = IQ, 1 = ECPU (registered)

## Operation
- FSM states: IDLE, HDR (only when the header macro is compiled in), IQ_BURST, CPU_MSG.
- Output register loads when `load = !a2f_we_o | a2f_rdy_i`. The source is popped in the same cycle it is loaded:
  - fifo_re_o = load & IQ_BURST & !fifo_empty_i
  - cpu_re_o = load & CPU_MSG & cpu_valid_i
- Arbitration happens in IDLE and at every grant end:
  - ECPU has priority when cpu_valid_i is high.
  - Exception: if the last grant was ECPU and !fifo_empty_i, IQ wins. This guarantees no starvation.
  - With neither source ready, go to or stay in IDLE.
- IQ_BURST:
  - A 16-bit burst counter increments per popped word.
  - The grant ends after BURST_LEN words, or at the first cycle with fifo_empty_i while load is high (early end, no wait).
- CPU_MSG:
  - The grant ends only on the popped word with cpu_last_i.
  - cpu_valid_i low mid-message stalls with no bubble word emitted. IQ is never interleaved into a message.
- Grant end with the next source ready: the next grant starts in the following load cycle with zero bubble.
- a2f_we_o deasserts only when a load occurs with nothing to load.
- Holding: while a2f_we_o & !a2f_rdy_i, a2f_data_o and a2f_we_o are stable and both pops are 0.

## Timing
- Reset values:
  - state IDLE, last grant IQ, counters 0
  - a2f_data_o 0, a2f_we_o 0, a2f_src_o 0
  - fifo_re_o 0, cpu_re_o 0
- Latency: source word popped in cycle N appears on a2f_data_o in cycle N+1.
- Throughput: 1 word/cycle while a2f_rdy_i is high and the granted source has data.
- Arbitration decision from IDLE: 1 cycle (the IDLE cycle itself emits nothing).
- Simultaneous events:
  - IQ burst limit reached while cpu_valid_i rises: ECPU is granted next.
  - cpu_last_i word popped while FIFO is non-empty: IQ is granted next.
- Reset mid-operation: all state is cleared immediately. A partially sent ECPU message or IQ burst is abandoned; the upstream sources are responsible for flushing.

## Configuration
- A2F_HDR_EN defined:
  - Each grant is preceded by one header word in state HDR. No source is popped during HDR.
  - Header layout: bit 23 = source, bits 22:16 = 7'h55, bits 15:0 = frame counter.
  - The frame counter increments per header and wraps at 16'hFFFF -> 0.
  - Header timing: the header word occupies the first load cycle of the grant.
- A2F_HDR_EN undefined: no HDR state, no frame counter, raw words only.

## Structure
- Package a2f_pkg holds:
  - the state enum
  - the source enum (SRC_IQ = 0, SRC_CPU = 1)
  - the sync constant 7'h55
  - header field offsets
- Sub-module a2f_out_reg: the one-entry output holding register (data, we, src) with the load/hold logic, instantiated once.

## Test plan
- IQ only, BURST_LEN = 4, 10 words in FIFO, rdy = 1 -> 10 words out in order; bursts of 4, 4, 2; a2f_src_o = 0; no bubbles after the first word.
- ECPU 3-word message (last on word 3) with the FIFO non-empty during the message -> 3 ECPU words contiguous, then IQ words; a2f_src_o switches 1 -> 0.
- Both sources ready continuously, BURST_LEN = 4, 2-word messages -> repeating pattern 2 CPU, 4 IQ, 2 CPU, …
- a2f_rdy_i toggles 1-0-1 each cycle during an IQ burst -> data is held while rdy = 0, no words are lost or duplicated, fifo_re_o = 0 in hold cycles.
- cpu_valid_i drops for 3 cycles mid-message while the FIFO is non-empty -> we drops, no IQ words are inserted, the message completes.
- A2F_HDR_EN defined, one IQ grant with frame counter preset near wrap -> header 0x55FFFF then 0x550000 on the next grant; reset mid-burst -> a2f_we_o = 0 and both pops = 0 immediately.
